// File: rtl/obstacle_avoid_ctrl.sv
// Obstacle-avoidance controller: echo fall detection, median-of-3 distance filter,
// forward/back/turn/lost motor FSM with a sample watchdog.
module obstacle_avoid_ctrl #(
    parameter int unsigned NEAR_CM     = 20,
    parameter int unsigned FAR_CM      = 30,
    parameter int unsigned BACK_CYC    = 8000,
    parameter int unsigned TURN_CYC    = 6000,
    parameter int unsigned TIMEOUT_CYC = 4000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       echo,
    input  logic [7:0] dis,
    output logic [7:0] dis_filt,
    output logic       sample_vld,
    output logic       near,
    output logic       lost,
    output logic [1:0] motor
);

    // State codes equal the motor command so motor is the state register itself.
    localparam logic [1:0] ST_LOST = 2'b00;
    localparam logic [1:0] ST_FWD  = 2'b01;
    localparam logic [1:0] ST_BACK = 2'b10;
    localparam logic [1:0] ST_TURN = 2'b11;

    localparam logic [7:0]  MAX_CM       = 8'd99;
    localparam logic [7:0]  NEAR_L       = 8'(NEAR_CM);
    localparam logic [7:0]  FAR_L        = 8'(FAR_CM);
    localparam logic [15:0] BACK_LAST    = 16'(BACK_CYC - 1);
    localparam logic [15:0] TURN_LAST    = 16'(TURN_CYC - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    function automatic logic [7:0] clamp_cm(input logic [7:0] d);
        return (d > MAX_CM) ? MAX_CM : d;
    endfunction

    function automatic logic [7:0] median3(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c < lo)      return lo;
        else if (c > hi) return hi;
        else             return c;
    endfunction

    logic        echo_p0, echo_p1, echo_p2;
    logic        fall;
    logic [7:0]  b0, b1;
    logic [7:0]  din;
    logic [7:0]  filt_nxt;
    logic [15:0] wdog;
    logic        timeout;
    logic [1:0]  state, state_nxt;
    logic [15:0] timer, timer_nxt;

    // Stage p0..p2: echo synchroniser and falling-edge detect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            echo_p0 <= 1'b0;
            echo_p1 <= 1'b0;
            echo_p2 <= 1'b0;
        end else begin
            echo_p0 <= echo;
            echo_p1 <= echo_p0;
            echo_p2 <= echo_p1;
        end
    end

    assign fall     = echo_p2 & ~echo_p1;
    assign din      = clamp_cm(dis);
    assign filt_nxt = median3(din, b0, b1);

    // Capture stage: sample history, filtered distance and its valid pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b0         <= MAX_CM;
            b1         <= MAX_CM;
            dis_filt   <= MAX_CM;
            near       <= 1'b0;
            sample_vld <= 1'b0;
        end else begin
            sample_vld <= fall;
            if (fall) begin
                b1       <= b0;
                b0       <= din;
                dis_filt <= filt_nxt;
                near     <= (filt_nxt < NEAR_L);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                wdog <= 16'd0;
        else if (fall)             wdog <= 16'd0;
        else if (wdog != 16'hFFFF) wdog <= wdog + 16'd1;
    end

    // A sample arriving on the expiry cycle cancels the timeout.
    assign timeout = !fall && (wdog == TIMEOUT_LAST);

    always_comb begin
        state_nxt = state;
        timer_nxt = 16'd0;
        if (timeout) begin
            state_nxt = ST_LOST;
        end else begin
            case (state)
                ST_LOST: if (sample_vld) state_nxt = (dis_filt >= FAR_L) ? ST_FWD : ST_BACK;
                ST_FWD:  if (dis_filt < NEAR_L) state_nxt = ST_BACK;
                ST_BACK: begin
                    if (timer == BACK_LAST) state_nxt = ST_TURN;
                    else                    timer_nxt = timer + 16'd1;
                end
                ST_TURN: begin
                    if (timer == TURN_LAST) begin
                        if (dis_filt >= FAR_L) state_nxt = ST_FWD;
                    end else begin
                        timer_nxt = timer + 16'd1;
                    end
                end
                default: state_nxt = ST_LOST;
            endcase
        end
    end

    // FSM stage: state and slot timer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_LOST;
            timer <= 16'd0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    assign motor = state;
    assign lost  = (state == ST_LOST);

endmodule

// File: tb/tb_obstacle_avoid_ctrl.sv
// Bench for obstacle_avoid_ctrl: directed scenarios plus random echoes, every cycle
// compared against a behavioural model of the sensor filter and avoidance rules.
module tb_obstacle_avoid_ctrl;

    localparam int NEAR    = 20;
    localparam int FAR     = 30;
    localparam int BACK    = 40;
    localparam int TURN    = 30;
    localparam int TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       echo;
    logic [7:0] dis;
    logic [7:0] dis_filt;
    logic       sample_vld;
    logic       near;
    logic       lost;
    logic [1:0] motor;

    obstacle_avoid_ctrl #(
        .NEAR_CM(NEAR), .FAR_CM(FAR), .BACK_CYC(BACK), .TURN_CYC(TURN), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .echo(echo), .dis(dis),
        .dis_filt(dis_filt), .sample_vld(sample_vld), .near(near), .lost(lost), .motor(motor)
    );

    always #5 clk = ~clk;

    typedef enum {M_LOST, M_FWD, M_BACK, M_TURN} mode_e;

    int    n_pass = 0;
    int    n_total = 0;
    int    n_fail = 0;

    // Behavioural model: echo history, sample buffer, mode and time spent in it
    int    m_hist [3];
    int    m_b0, m_b1;
    int    m_filt;
    bit    m_vld, m_near;
    int    m_idle;
    mode_e m_mode;
    int    m_t;

    int    back_run = 0;
    bit    saw_lost = 0;

    function automatic logic [1:0] motor_of(input mode_e m);
        case (m)
            M_FWD:   return 2'b01;
            M_BACK:  return 2'b10;
            M_TURN:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit    cap;
        mode_e nm;
        int    nt;
        int    d;
        int    q [$];
        if (!rst_n) begin
            m_hist = '{0, 0, 0};
            m_b0 = 99; m_b1 = 99; m_filt = 99;
            m_vld = 0; m_near = 0; m_idle = 0;
            m_mode = M_LOST; m_t = 0;
            return;
        end
        cap = (m_hist[2] == 1) && (m_hist[1] == 0);
        nm  = m_mode;
        nt  = m_t + 1;
        if (!cap && m_idle == TIMEOUT - 1) begin
            nm = M_LOST;
        end else begin
            case (m_mode)
                M_LOST: if (m_vld) nm = (m_filt >= FAR) ? M_FWD : M_BACK;
                M_FWD:  if (m_filt < NEAR) nm = M_BACK;
                M_BACK: if (m_t == BACK - 1) nm = M_TURN;
                M_TURN: if (m_t == TURN - 1) begin
                    if (m_filt >= FAR) nm = M_FWD;
                    else               nt = 0;
                end
                default: nm = M_LOST;
            endcase
        end
        if (nm != m_mode) nt = 0;
        m_mode = nm;
        m_t    = nt;
        if (cap) begin
            d = (int'(dis) > 99) ? 99 : int'(dis);
            q = '{d, m_b0, m_b1};
            q.sort();
            m_filt = q[1];
            m_b1   = m_b0;
            m_b0   = d;
            m_near = (m_filt < NEAR);
            m_vld  = 1;
            m_idle = 0;
        end else begin
            m_vld = 0;
            m_idle++;
        end
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = int'(echo);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("motor",    16'(motor),      16'(motor_of(m_mode)));
        check("lost",     16'(lost),       16'(m_mode == M_LOST));
        check("dis_filt", 16'(dis_filt),   16'(m_filt));
        check("vld",      16'(sample_vld), 16'(m_vld));
        check("near",     16'(near),       16'(m_near));
        if (motor == 2'b10) begin
            back_run++;
        end else begin
            if (back_run > 0 && motor == 2'b11) check("back_len", 16'(back_run), 16'(BACK));
            back_run = 0;
        end
        if (lost) saw_lost = 1;
    endtask

    // Echo high for 'high' cycles, then low for 'low' cycles with the new distance on dis
    task automatic send_echo(input int d, input int high, input int low, input bit lat_chk);
        echo = 1'b1;
        repeat (high) cycle();
        echo = 1'b0;
        dis  = 8'(d);
        for (int k = 1; k <= low; k++) begin
            cycle();
            if (lat_chk && k <= 3) check("latency", 16'(sample_vld), 16'(k == 3));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        echo  = 1'b0;
        dis   = 8'd0;
        repeat (2) cycle();
        check("rst_motor", 16'(motor), 16'd0);
        check("rst_lost",  16'(lost), 16'd1);
        check("rst_filt",  16'(dis_filt), 16'd99);
        check("rst_vld",   16'(sample_vld), 16'd0);
        rst_n = 1'b1;

        send_echo(50, 4, 5, 1);
        check("first_filt", 16'(dis_filt), 16'd99);
        check("first_fwd",  16'(motor), 16'd1);
        repeat (2) send_echo(50, 4, 5, 1);
        check("filt_50", 16'(dis_filt), 16'd50);

        send_echo(50, 4, 5, 1);
        send_echo(50, 4, 5, 1);
        send_echo(10, 4, 5, 1);
        check("spike_filt", 16'(dis_filt), 16'd50);
        send_echo(50, 4, 5, 1);
        check("spike_filt2", 16'(dis_filt), 16'd50);
        check("spike_near",  16'(near), 16'd0);
        check("spike_motor", 16'(motor), 16'd1);

        repeat (3) send_echo(15, 3, 5, 1);
        check("avoid_near", 16'(near), 16'd1);
        repeat (10) send_echo(25, 3, 5, 1);
        check("turn_repeat", 16'(motor), 16'd3);
        repeat (2) send_echo(40, 3, 5, 1);
        repeat (35) cycle();
        check("turn_to_fwd", 16'(motor), 16'd1);

        repeat (TIMEOUT + 5) cycle();
        check("timeout_motor", 16'(motor), 16'd0);
        check("timeout_lost",  16'(lost), 16'd1);
        send_echo(40, 3, 5, 1);
        saw_lost = 0;
        send_echo(40, TIMEOUT - 4, 5, 1);
        check("late_fall_lost", 16'(saw_lost), 16'd1);
        saw_lost = 0;
        send_echo(40, TIMEOUT - 5, 5, 1);
        check("edge_fall_nolost", 16'(saw_lost), 16'd0);
        check("edge_fall_motor",  16'(motor), 16'd1);

        repeat (3) send_echo(200, 3, 5, 1);
        check("clamp_filt", 16'(dis_filt), 16'd99);
        repeat (2) send_echo(5, 3, 5, 1);
        repeat (10) cycle();
        check("mid_back", 16'(motor), 16'd2);
        rst_n = 1'b0;
        cycle();
        check("rst2_motor", 16'(motor), 16'd0);
        check("rst2_lost",  16'(lost), 16'd1);
        check("rst2_filt",  16'(dis_filt), 16'd99);
        check("rst2_near",  16'(near), 16'd0);
        rst_n = 1'b1;
        repeat (2) send_echo(5, 3, 5, 1);
        repeat (50) cycle();
        check("back_again_turn", 16'(motor), 16'd3);

        for (int i = 0; i < 60; i++) begin
            int d;
            d = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255))
                                           : int'($urandom_range(12, 36));
            send_echo(d, int'($urandom_range(1, 10)), int'($urandom_range(1, 8)), 1'b0);
            if ($urandom_range(0, 9) == 0) repeat ($urandom_range(50, 150)) cycle();
            if ($urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                cycle();
                rst_n = 1'b1;
            end
        end
        repeat (20) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
